// File: rtl/bp_cce_mmio_cfg_arbiter_if.sv
// Config/IO channel bundle: requester-side command/response lanes
// plus the single arbitrated downstream command/response channel.
interface bp_cce_mmio_cfg_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128
);

    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;

    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_ready_i;

    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_yumi_i;

    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_yumi_o;

    modport slave (
        input  req_cmd_i,
        input  req_cmd_v_i,
        output req_cmd_yumi_o,
        output req_resp_o,
        output req_resp_v_o,
        input  req_resp_ready_i,
        output io_cmd_o,
        output io_cmd_v_o,
        input  io_cmd_yumi_i,
        input  io_resp_i,
        input  io_resp_v_i,
        output io_resp_yumi_o
    );

    modport master (
        output req_cmd_i,
        output req_cmd_v_i,
        input  req_cmd_yumi_o,
        input  req_resp_o,
        input  req_resp_v_o,
        output req_resp_ready_i,
        input  io_cmd_o,
        input  io_cmd_v_o,
        output io_cmd_yumi_i,
        output io_resp_i,
        output io_resp_v_i,
        input  io_resp_yumi_o
    );

endinterface

// File: rtl/bp_cce_mmio_cfg_arbiter.sv
// Round-robin, lock-until-accept arbiter for a shared config/IO channel
// with credit-limited outstanding commands and in-order response routing.
module bp_cce_mmio_cfg_arbiter #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 128,
    parameter int max_credits_p = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_cce_mmio_cfg_arbiter_if.slave    bus,
    output logic                        idle_o,
    output logic                        error_o
);

    localparam int id_width_lp  = (num_req_p > 2) ? $clog2(num_req_p) : 1;
    localparam int cnt_width_lp = $clog2(max_credits_p + 1);
    localparam int ptr_width_lp = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;

    typedef logic [id_width_lp-1:0]  id_t;
    typedef logic [cnt_width_lp-1:0] cnt_t;
    typedef logic [ptr_width_lp-1:0] ptr_t;

    id_t  rr_ptr_q, rr_ptr_d;
    id_t  lock_id_q, lock_id_d;
    logic lock_q, lock_d;
    logic err_q, err_d;
    cnt_t cnt_q, cnt_d;
    ptr_t wr_q, wr_d;
    ptr_t rd_q, rd_d;

    id_t  tag_mem [max_credits_p];

    id_t  cand;
    id_t  grant;
    id_t  head;
    int   idx;
    logic any_v;
    logic full;
    logic empty;
    logic cmd_v;
    logic accept;
    logic pop;
    logic stray;

    function automatic ptr_t wrap_inc(input ptr_t p);
        return (p == ptr_t'(max_credits_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reverse scan so the last hit is the first requester at/after the pointer
    always_comb begin
        cand = rr_ptr_q;
        idx  = 0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % num_req_p;
            if (bus.req_cmd_v_i[idx]) begin
                cand = id_t'(idx);
            end
        end
    end

    assign any_v  = |bus.req_cmd_v_i;
    assign full   = (cnt_q == cnt_t'(max_credits_p));
    assign empty  = (cnt_q == '0);
    assign grant  = lock_q ? lock_id_q : cand;
    assign cmd_v  = ~full & (lock_q | any_v);
    assign accept = cmd_v & bus.io_cmd_yumi_i;

    assign bus.io_cmd_v_o = cmd_v;
    assign bus.io_cmd_o   = bus.req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];

    always_comb begin
        bus.req_cmd_yumi_o = '0;
        if (accept) begin
            bus.req_cmd_yumi_o[grant] = 1'b1;
        end
    end

    assign head  = tag_mem[rd_q];
    assign stray = bus.io_resp_v_i & empty;
    assign pop   = bus.io_resp_v_i & ~empty & bus.req_resp_ready_i[head];

    // A stray response is swallowed so the channel never stalls on it
    assign bus.io_resp_yumi_o = pop | stray;
    assign bus.req_resp_o     = bus.io_resp_i;

    always_comb begin
        bus.req_resp_v_o = '0;
        if (bus.io_resp_v_i && !empty) begin
            bus.req_resp_v_o[head] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            rr_ptr_d = (grant == id_t'(num_req_p - 1)) ? '0 : grant + 1'b1;
            lock_d   = 1'b0;
        end else if (cmd_v) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        wr_d  = accept ? wrap_inc(wr_q) : wr_q;
        rd_d  = pop ? wrap_inc(rd_q) : rd_q;
        err_d = err_q | stray;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    // Tag storage needs no reset: occupancy is tracked by cnt_q
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_mem[wr_q] <= grant;
        end
    end

    assign idle_o  = empty & ~lock_q;
    assign error_o = err_q;

endmodule

// File: tb/tb_bp_cce_mmio_cfg_arbiter.sv
// Randomized scoreboard bench for the config/IO channel arbiter.
module tb_bp_cce_mmio_cfg_arbiter;

    localparam int N = 3;
    localparam int W = 32;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    logic idle;
    logic err;

    always #5 clk = ~clk;

    bp_cce_mmio_cfg_arbiter_if #(.num_req_p(N), .msg_width_p(W)) bus_if ();

    bp_cce_mmio_cfg_arbiter #(
        .num_req_p    (N),
        .msg_width_p  (W),
        .max_credits_p(C)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus_if),
        .idle_o (idle),
        .error_o(err)
    );

    typedef struct {
        logic         v;
        logic [N-1:0] cyumi;
        logic [W-1:0] cmd;
        logic         idle;
        logic         err;
    } cyc_t;

    typedef struct {
        logic [N-1:0] rv;
        logic         ryumi;
        logic [W-1:0] data;
    } rsp_t;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int           m_ptr  = 0;
    bit           m_lock = 0;
    int           m_lid  = 0;
    bit           m_err  = 0;
    int           tagq[$];
    bit           hold[N];
    logic [W-1:0] dat[N];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input int p_v, input int p_y, input int p_r,
                         input int p_rdy, input bit stray_ok, input bit do_rst);
        cyc_t         c;
        rsp_t         r;
        logic [N-1:0] vv;
        logic [N-1:0] rdy;
        logic         yumi;
        logic         rspv;
        logic [W-1:0] rd;
        int           g;
        bit           found;
        bit           ev;
        bit           do_pop;

        @(posedge clk);
        #1;
        rst = do_rst;
        for (int k = 0; k < N; k++) begin
            if (do_rst) begin
                hold[k] = 0;
            end else if (!hold[k] && $urandom_range(99) < p_v) begin
                hold[k] = 1;
                dat[k]  = $urandom;
            end
            vv[k]  = hold[k];
            rdy[k] = ($urandom_range(99) < p_rdy);
            bus_if.req_cmd_i[k*W +: W] = dat[k];
        end
        yumi = !do_rst && ($urandom_range(99) < p_y);
        rspv = !do_rst && (tagq.size() > 0 || stray_ok) &&
               ($urandom_range(99) < p_r);
        rd   = $urandom;
        bus_if.req_cmd_v_i      = vv;
        bus_if.io_cmd_yumi_i    = yumi;
        bus_if.io_resp_v_i      = rspv;
        bus_if.io_resp_i        = rd;
        bus_if.req_resp_ready_i = rdy;

        // grant: locked owner, else first valid scanning up from the pointer
        g     = m_lid;
        found = 0;
        if (!m_lock) begin
            for (int i = 0; i < N; i++) begin
                if (!found && vv[(m_ptr + i) % N]) begin
                    g     = (m_ptr + i) % N;
                    found = 1;
                end
            end
        end
        ev = (m_lock || found) && (tagq.size() < C);

        c.v     = ev;
        c.cyumi = '0;
        if (ev && yumi) c.cyumi[g] = 1'b1;
        c.cmd   = dat[g];
        c.idle  = (tagq.size() == 0) && !m_lock;
        c.err   = m_err;
        cyc_q.push_back(c);

        do_pop = 0;
        if (rspv) begin
            r.data = rd;
            r.rv   = '0;
            if (tagq.size() == 0) begin
                r.ryumi = 1'b1;
            end else begin
                r.rv[tagq[0]] = 1'b1;
                r.ryumi       = rdy[tagq[0]];
                do_pop        = rdy[tagq[0]];
            end
            rsp_q.push_back(r);
        end

        if (do_rst) begin
            m_ptr  = 0;
            m_lock = 0;
            m_lid  = 0;
            m_err  = 0;
            tagq.delete();
        end else begin
            if (rspv && tagq.size() == 0) m_err = 1;
            if (do_pop) void'(tagq.pop_front());
            if (ev && yumi) begin
                tagq.push_back(g);
                hold[g] = 0;
                m_ptr   = (g + 1) % N;
                m_lock  = 0;
            end else if (ev) begin
                m_lock = 1;
                m_lid  = g;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc_t c;
        rsp_t r;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("io_cmd_v", 64'(bus_if.io_cmd_v_o), 64'(c.v));
            chk("req_cmd_yumi", 64'(bus_if.req_cmd_yumi_o), 64'(c.cyumi));
            chk("idle", 64'(idle), 64'(c.idle));
            chk("error", 64'(err), 64'(c.err));
            if (c.cyumi != '0) begin
                chk("io_cmd_data", 64'(bus_if.io_cmd_o), 64'(c.cmd));
            end
            if (bus_if.io_resp_v_i) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_queue_nonempty", 64'(0), 64'(1));
                end else begin
                    r = rsp_q.pop_front();
                    chk("req_resp_v", 64'(bus_if.req_resp_v_o), 64'(r.rv));
                    chk("io_resp_yumi", 64'(bus_if.io_resp_yumi_o), 64'(r.ryumi));
                    chk("req_resp_data", 64'(bus_if.req_resp_o), 64'(r.data));
                end
            end else begin
                chk("req_resp_v_idle", 64'(bus_if.req_resp_v_o), 64'(0));
                chk("io_resp_yumi_idle", 64'(bus_if.io_resp_yumi_o), 64'(0));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus_if.req_cmd_i        = '0;
        bus_if.req_cmd_v_i      = '0;
        bus_if.io_cmd_yumi_i    = 1'b0;
        bus_if.io_resp_i        = '0;
        bus_if.io_resp_v_i      = 1'b0;
        bus_if.req_resp_ready_i = '0;
        for (int k = 0; k < N; k++) begin
            hold[k] = 0;
            dat[k]  = '0;
        end
        repeat (2) @(posedge clk);

        // busy traffic with prompt returns
        repeat (400) cycle(70, 70, 60, 80, 0, 0);
        // responses withheld: credits fill up and the channel stalls
        repeat (150) cycle(80, 90, 0, 80, 0, 0);
        // slow owners and frequent locks
        repeat (300) cycle(60, 30, 50, 40, 0, 0);
        // drain, then stray responses while idle
        repeat (40) cycle(0, 90, 90, 100, 0, 0);
        repeat (20) cycle(0, 0, 50, 100, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        repeat (200) cycle(70, 50, 50, 70, 0, 0);
        // reset with commands in flight
        cycle(0, 0, 0, 0, 0, 1);
        repeat (300) cycle(70, 60, 55, 60, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        repeat (10) cycle(50, 50, 50, 50, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("cyc_q_drained", 64'(cyc_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
